// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction and writeback source selection.
// It also holds the retired-instruction counter and drives the register-file write port.
module mem_wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_regwrite,
    input  logic [4:0]       in_rd,
    input  logic [1:0]       in_wb_sel,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_alu_out,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             rf_load,
    output logic [4:0]       rf_rd,
    output logic [XLEN-1:0]  rf_in,
    output logic             fwd_valid,
    output logic             wb_valid,
    output logic             misalign,
    output logic [CNT_W-1:0] instret
);

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Picks the addressed byte/half out of the aligned word; unknown funct3 yields zero.
    function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3,
                                                     input logic [1:0] off,
                                                     input logic [XLEN-1:0] word);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [XLEN-1:0] res;
        case (off)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   res = {{24{byte_v[7]}}, byte_v};
            F3_LBU:  res = {24'd0, byte_v};
            F3_LH:   res = {{16{half_v[15]}}, half_v};
            F3_LHU:  res = {16'd0, half_v};
            F3_LW:   res = word;
            default: res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3)
            F3_LH, F3_LHU: mis = off[0];
            F3_LW:         mis = (off != 2'd0);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

    logic             valid_q, valid_d;
    logic             regwrite_q, regwrite_d;
    logic [4:0]       rd_q, rd_d;
    logic [1:0]       wb_sel_q, wb_sel_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [XLEN-1:0]  alu_out_q, alu_out_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire_s;
    logic             misalign_s;
    logic [XLEN-1:0]  wb_data_s;

    // Next-state for the WB register: flush beats stall, stall holds, otherwise capture.
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        rd_d       = rd_q;
        wb_sel_d   = wb_sel_q;
        funct3_d   = funct3_q;
        alu_out_d  = alu_out_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        rdata_d    = rdata_q;
        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            rd_d       = 5'd0;
            wb_sel_d   = 2'd0;
            funct3_d   = 3'd0;
            alu_out_d  = {XLEN{1'b0}};
            pc_d       = {XLEN{1'b0}};
            imm_d      = {XLEN{1'b0}};
            rdata_d    = {XLEN{1'b0}};
        end else if (!stall) begin
            valid_d    = in_valid;
            regwrite_d = in_regwrite;
            rd_d       = in_rd;
            wb_sel_d   = in_wb_sel;
            funct3_d   = in_funct3;
            alu_out_d  = in_alu_out;
            pc_d       = in_pc;
            imm_d      = in_imm;
            rdata_d    = mem_rdata;
        end else begin
            valid_d    = valid_q;
        end
    end

    // The WB instruction retires whenever it leaves the register, including via flush.
    always_comb begin
        retire_s  = valid_q & (~stall | flush);
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire_s};
    end

    // WB register and retired counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= 5'd0;
            wb_sel_q   <= 2'd0;
            funct3_q   <= 3'd0;
            alu_out_q  <= {XLEN{1'b0}};
            pc_q       <= {XLEN{1'b0}};
            imm_q      <= {XLEN{1'b0}};
            rdata_q    <= {XLEN{1'b0}};
            instret_q  <= {CNT_W{1'b0}};
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wb_sel_q   <= wb_sel_d;
            funct3_q   <= funct3_d;
            alu_out_q  <= alu_out_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            rdata_q    <= rdata_d;
            instret_q  <= instret_d;
        end
    end

    // Writeback formatting, driven purely from the WB register.
    always_comb begin
        misalign_s = valid_q & (wb_sel_q == WB_LOAD) & load_misaligned(funct3_q, alu_out_q[1:0]);
        case (wb_sel_q)
            WB_ALU:  wb_data_s = alu_out_q;
            WB_LOAD: wb_data_s = load_extract(funct3_q, alu_out_q[1:0], rdata_q);
            WB_PC4:  wb_data_s = pc_q + 32'd4;
            default: wb_data_s = imm_q;
        endcase
    end

    assign rf_load   = valid_q & regwrite_q & (rd_q != 5'd0) & ~misalign_s;
    assign fwd_valid = rf_load;
    assign rf_rd     = rd_q;
    assign rf_in     = wb_data_s;
    assign wb_valid  = valid_q;
    assign misalign  = misalign_s;
    assign instret   = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized bench for mem_wb_stage against a behavioural model of the WB slot.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        in_valid, in_regwrite;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_out, in_pc, in_imm, mem_rdata;
    logic        rf_load, fwd_valid, wb_valid, misalign;
    logic [4:0]  rf_rd;
    logic [31:0] rf_in;
    logic [63:0] instret;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        bit          valid;
        bit          rw;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rdata;
    } txn_t;

    txn_t        m;
    logic [63:0] m_cnt;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_regwrite(in_regwrite), .in_rd(in_rd),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_alu_out(in_alu_out),
        .in_pc(in_pc), .in_imm(in_imm), .mem_rdata(mem_rdata),
        .rf_load(rf_load), .rf_rd(rf_rd), .rf_in(rf_in), .fwd_valid(fwd_valid),
        .wb_valid(wb_valid), .misalign(misalign), .instret(instret)
    );

    function automatic txn_t zero_txn();
        txn_t t;
        t.valid = 1'b0; t.rw = 1'b0; t.rd = 5'd0; t.sel = 2'd0; t.f3 = 3'd0;
        t.alu = 32'd0; t.pc = 32'd0; t.imm = 32'd0; t.rdata = 32'd0;
        return t;
    endfunction

    function automatic bit exp_mis(txn_t t);
        int off;
        off = int'(t.alu[1:0]);
        if (!t.valid || t.sel != 2'd1) return 1'b0;
        if ((t.f3 == 3'd1 || t.f3 == 3'd5) && (off % 2 != 0)) return 1'b1;
        if (t.f3 == 3'd2 && off != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_data(txn_t t);
        int unsigned off, b, h;
        off = int'(t.alu[1:0]);
        b = (t.rdata >> (8 * off)) & 32'hFF;
        h = (t.rdata >> (16 * (off / 2))) & 32'hFFFF;
        case (t.sel)
            2'd0: return t.alu;
            2'd2: return t.pc + 32'd4;
            2'd3: return t.imm;
            default: begin
                if (t.f3 == 3'd0) return (b >= 128) ? (b - 256) : b;
                if (t.f3 == 3'd4) return b;
                if (t.f3 == 3'd1) return (h >= 32768) ? (h - 65536) : h;
                if (t.f3 == 3'd5) return h;
                if (t.f3 == 3'd2) return t.rdata;
                return 32'd0;
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit e_mis, e_load;
        e_mis  = exp_mis(m);
        e_load = m.valid && m.rw && (m.rd != 5'd0) && !e_mis;
        chk("wb_valid",  {63'd0, wb_valid},  {63'd0, m.valid});
        chk("misalign",  {63'd0, misalign},  {63'd0, e_mis});
        chk("rf_load",   {63'd0, rf_load},   {63'd0, e_load});
        chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, e_load});
        chk("rf_rd",     {59'd0, rf_rd},     {59'd0, m.rd});
        chk("rf_in",     {32'd0, rf_in},     {32'd0, exp_data(m)});
        chk("instret",   instret,            m_cnt);
    endtask

    task automatic drive(input bit v, input bit rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rdata);
        in_valid = v; in_regwrite = rw; in_rd = rd; in_wb_sel = sel; in_funct3 = f3;
        in_alu_out = alu; in_pc = pc; in_imm = imm; mem_rdata = rdata;
    endtask

    // One clock edge, with the model updated from the inputs seen at that edge.
    task automatic tick();
        txn_t cur;
        cur.valid = in_valid; cur.rw = in_regwrite; cur.rd = in_rd; cur.sel = in_wb_sel;
        cur.f3 = in_funct3; cur.alu = in_alu_out; cur.pc = in_pc; cur.imm = in_imm;
        cur.rdata = mem_rdata;
        @(posedge clk);
        if (m.valid && (!stall || flush)) m_cnt = m_cnt + 64'd1;
        if (flush) m = zero_txn();
        else if (!stall) m = cur;
        #1;
    endtask

    logic [2:0]  ld_f3  [6] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd2};
    logic [1:0]  ld_off [6] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd2};
    logic [31:0] ld_exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                                32'h00007F01, 32'h80FF7F01, 32'h80FF7F01};
    logic [2:0]  rnd_f3 [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};

    initial begin
        logic [63:0] saved_cnt;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        m = zero_txn(); m_cnt = 64'd0;
        #12;
        check_all();
        rst_n = 1'b1;
        @(negedge clk);

        // ALU writeback, then the same with rd=0
        drive(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'hDEADBEEF, 32'h100, 32'd0, 32'd0);
        tick(); check_all();
        chk("alu_rf_in", {32'd0, rf_in}, 64'h00000000DEADBEEF);
        chk("alu_rf_load", {63'd0, rf_load}, 64'd1);
        chk("alu_instret_not_yet", instret, 64'd0);
        drive(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 32'hDEADBEEF, 32'h104, 32'd0, 32'd0);
        tick(); check_all();
        chk("rd0_rf_load", {63'd0, rf_load}, 64'd0);
        chk("rd0_instret", instret, 64'd1);
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick(); check_all();
        chk("rd0_retired", instret, 64'd2);

        // Load extraction table
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 5'd9, 2'd1, ld_f3[i], {30'h0000100, ld_off[i]}, 32'h200, 32'd0,
                  32'h80FF7F01);
            tick(); check_all();
            chk("load_data", {32'd0, rf_in}, {32'd0, ld_exp[i]});
        end
        chk("lw_misalign", {63'd0, misalign}, 64'd1);
        chk("lw_mis_rf_load", {63'd0, rf_load}, 64'd0);

        // Other writeback sources
        drive(1'b1, 1'b1, 5'd3, 2'd2, 3'd0, 32'd0, 32'hFFFFFFFC, 32'd0, 32'd0);
        tick(); check_all();
        chk("pc4_wrap", {32'd0, rf_in}, 64'd0);
        drive(1'b1, 1'b1, 5'd3, 2'd3, 3'd0, 32'd0, 32'd0, 32'h12345000, 32'd0);
        tick(); check_all();
        chk("imm", {32'd0, rf_in}, 64'h0000000012345000);

        // Stall holds, then stall+flush retires and bubbles
        drive(1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 32'h11111111, 32'd0, 32'd0, 32'd0);
        tick(); check_all();
        saved_cnt = m_cnt;
        stall = 1'b1;
        drive(1'b1, 1'b1, 5'd8, 2'd0, 3'd0, 32'h22222222, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); check_all();
            chk("stall_hold_data", {32'd0, rf_in}, 64'h0000000011111111);
            chk("stall_hold_load", {63'd0, rf_load}, 64'd1);
            chk("stall_instret", instret, saved_cnt);
        end
        flush = 1'b1;
        tick(); check_all();
        chk("flush_instret", instret, saved_cnt + 64'd1);
        chk("flush_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("flush_rf_load", {63'd0, rf_load}, 64'd0);
        stall = 1'b0; flush = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 9) == 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom), 2'($urandom),
                  rnd_f3[$urandom_range(0, 6)], $urandom, $urandom, $urandom, $urandom);
            tick(); check_all();
        end

        // Counter wrap: preload all-ones, then retire one instruction
        stall = 1'b0; flush = 1'b0;
        drive(1'b1, 1'b1, 5'd4, 2'd0, 3'd0, 32'h0000ABCD, 32'd0, 32'd0, 32'd0);
        tick(); check_all();
        stall = 1'b1;
        force dut.instret_d = 64'hFFFFFFFF_FFFFFFFF;
        tick();
        release dut.instret_d;
        m_cnt = 64'hFFFFFFFF_FFFFFFFF;
        check_all();
        stall = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick(); check_all();
        chk("instret_wrap", instret, 64'd0);

        // Asynchronous reset mid-cycle with a valid instruction in WB
        drive(1'b1, 1'b1, 5'd6, 2'd0, 3'd0, 32'h5A5A5A5A, 32'd0, 32'd0, 32'd0);
        tick();
        drive(1'b1, 1'b1, 5'd6, 2'd0, 3'd0, 32'h5A5A5A5A, 32'd0, 32'd0, 32'd0);
        tick(); check_all();
        chk("pre_reset_load", {63'd0, rf_load}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        m = zero_txn(); m_cnt = 64'd0;
        check_all();
        chk("async_rf_load", {63'd0, rf_load}, 64'd0);
        chk("async_instret", instret, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick(); check_all();
            chk("post_reset_load", {63'd0, rf_load}, 64'd0);
            chk("post_reset_instret", instret, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
